// File: rtl/multi_edge_filter.sv
// multi_edge_filter: per-channel synchronizer, DEPTH-sample agreement filter, edge pulses and idle flag
module multi_edge_filter #(
  parameter int CHANNELS    = 2,
  parameter int DEPTH       = 8,
  parameter bit RESET_LEVEL = 1'b1,
  parameter int IDLE_CYCLES = 2500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise_edge,
  output logic [CHANNELS-1:0] fall_edge,
  output logic [CHANNELS-1:0] any_edge,
  output logic [CHANNELS-1:0] idle
);
  localparam int CW = $clog2(IDLE_CYCLES + 1);
  logic [CHANNELS-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync1 <= {CHANNELS{RESET_LEVEL}};
      sync2 <= {CHANNELS{RESET_LEVEL}};
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  assign any_edge = rise_edge | fall_edge;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DEPTH-1:0] win, win_next;
    logic [CW-1:0] cnt, cnt_next;
    logic lvl, lvl_next, rise_q, fall_q, idle_q;
    // level decision looks at the window as it will be after this shift
    always_comb begin
      win_next = sample_en ? {win[DEPTH-2:0], sync2[c]} : win;
      lvl_next = !sample_en ? lvl : &win_next ? 1'b1 : ~|win_next ? 1'b0 : lvl;
      cnt_next = !lvl_next ? '0 : (sample_en && cnt != CW'(IDLE_CYCLES)) ? cnt + CW'(1) : cnt;
    end
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        win    <= {DEPTH{RESET_LEVEL}};
        lvl    <= RESET_LEVEL;
        cnt    <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        idle_q <= 1'b0;
      end else begin
        win    <= win_next;
        lvl    <= lvl_next;
        cnt    <= cnt_next;
        rise_q <= lvl_next & ~lvl;
        fall_q <= ~lvl_next & lvl;
        idle_q <= cnt_next == CW'(IDLE_CYCLES);
      end
    assign level[c]     = lvl;
    assign rise_edge[c] = rise_q;
    assign fall_edge[c] = fall_q;
    assign idle[c]      = idle_q;
  end
endmodule

// File: tb/tb_multi_edge_filter.sv
// tb_multi_edge_filter: scoreboard bench; a run-length reference model predicts every output each cycle
module tb_multi_edge_filter;
  localparam int DEPTH = 8;
  localparam int IDLE  = 20;
  logic clk, rst, sample_en;
  logic [1:0] din, level, rise_edge, fall_edge, any_edge, idle;
  int tests = 0, fails = 0, cyc = 0, npulse = 0, nfall = 0, nrise = 0, last_pulse = 0, t0 = 0, first = 0;
  logic [7:0] sb[$];
  logic [1:0] m_s1, m_s2, rv, ml, mr, mf, mi;
  int rc[2], mc[2];

  multi_edge_filter #(.CHANNELS(2), .DEPTH(DEPTH), .RESET_LEVEL(1'b1), .IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .din(din), .level(level),
    .rise_edge(rise_edge), .fall_edge(fall_edge), .any_edge(any_edge), .idle(idle)
  );

  initial clk = 0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 2'b11; m_s2 = 2'b11; rv = 2'b11; ml = 2'b11;
    mr = 0; mf = 0; mi = 0;
    for (int c = 0; c < 2; c++) begin rc[c] = DEPTH; mc[c] = 0; end
  endtask

  // level takes a value once DEPTH consecutive samples of it have been seen
  task automatic model_edge(input logic [1:0] d, input logic se);
    for (int c = 0; c < 2; c++) begin
      logic old;
      old = ml[c];
      if (se) begin
        if (m_s2[c] == rv[c]) rc[c] = (rc[c] < DEPTH) ? rc[c] + 1 : DEPTH;
        else begin rv[c] = m_s2[c]; rc[c] = 1; end
        if (rc[c] == DEPTH) ml[c] = rv[c];
      end
      mr[c] = ml[c] & ~old;
      mf[c] = ~ml[c] & old;
      if (!ml[c]) mc[c] = 0;
      else if (se && mc[c] < IDLE) mc[c]++;
      mi[c] = (mc[c] == IDLE);
      m_s2[c] = m_s1[c];
      m_s1[c] = d[c];
    end
  endtask

  task automatic step(input logic [1:0] d, input logic se);
    logic [7:0] e;
    @(negedge clk);
    din = d;
    sample_en = se;
    model_edge(d, se);
    sb.push_back({ml, mr, mf, mi});
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    chk("level", level, e[7:6]);
    chk("rise", rise_edge, e[5:4]);
    chk("fall", fall_edge, e[3:2]);
    chk("any", any_edge, e[5:4] | e[3:2]);
    chk("idle", idle, e[1:0]);
    if (any_edge[0]) begin npulse++; last_pulse = cyc; end
    if (fall_edge[0]) nfall++;
    if (rise_edge[0]) nrise++;
  endtask

  task automatic run(input int n, input logic [1:0] d, input int per);
    for (int i = 0; i < n; i++) step(d, (cyc % per) == 0);
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_level"}, level, 2'b11);
    chk({tag, "_rise"}, rise_edge, 2'b00);
    chk({tag, "_fall"}, fall_edge, 2'b00);
    chk({tag, "_any"}, any_edge, 2'b00);
    chk({tag, "_idle"}, idle, 2'b00);
  endtask

  initial begin
    rst = 0; din = 2'b11; sample_en = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_check("por");
    #1 rst = 1;
    // idle must fill from zero even though level resets high
    first = -1;
    for (int i = 0; i < 25; i++) begin
      step(2'b11, 1);
      if (idle[0] && first < 0) first = cyc;
    end
    chk("idle_fill", first, IDLE);
    nfall = 0; run(10, 2'b10, 1);
    chk("idle_low_falls", nfall, 1);
    chk("idle_low_idle", idle[0], 0);
    run(40, 2'b11, 1);
    chk("idle_back", idle[0], 1);
    // square wave: one pulse per half period, DEPTH+1 steps after the driving step
    for (int k = 0; k < 6; k++) begin
      npulse = 0; t0 = cyc + 1;
      run(40, {1'b1, k[0]}, 1);
      chk("sq_pulses", npulse, 1);
      chk("sq_lag", last_pulse - t0, DEPTH + 1);
    end
    npulse = 0;
    for (int g = 1; g < 8; g++) begin
      run(g, 2'b10, 1);
      run(20, 2'b11, 1);
    end
    chk("glitch_pulses", npulse, 0);
    nfall = 0; nrise = 0;
    run(8, 2'b10, 1);
    run(20, 2'b11, 1);
    chk("glitch8_falls", nfall, 1);
    chk("glitch8_rises", nrise, 1);
    npulse = 0;
    for (int i = 0; i < 100; i++) step({1'b1, ((i / 3) % 2) == 1}, 1);
    chk("bounce_pulses", npulse, 0);
    npulse = 0; nfall = 0; t0 = cyc + 1;
    run(20, 2'b10, 1);
    chk("settle_falls", nfall, 1);
    chk("settle_lag", last_pulse - t0, DEPTH + 1);
    run(40, 2'b11, 1);
    npulse = 0; nfall = 0;
    run(60, 2'b10, 4);
    chk("pre_pulses", npulse, 1);
    chk("pre_falls", nfall, 1);
    chk("pre_level", level[0], 0);
    run(40, 2'b11, 1);
    // five low samples in, then an asynchronous reset between edges
    run(7, 2'b10, 1);
    chk("pre_async_level", level[0], 1);
    #4 rst = 0;
    #1 rst_check("async");
    model_reset();
    #1 rst = 1;
    npulse = 0; nfall = 0; t0 = cyc + 1;
    run(15, 2'b10, 1);
    chk("async_falls", nfall, 1);
    chk("async_lag", last_pulse - t0, DEPTH + 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
